// File: rtl/color_bbox_scanner_pkg.sv
// Shared definitions for the colour bounding-box scanner: FSM states, default
// frame geometry, RGB444 field positions and the default target-colour thresholds.
package color_bbox_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4,
    ST_ACK_WAIT = 3'd5
  } scan_state_t;

  localparam int DEF_H_RES  = 320;
  localparam int DEF_V_RES  = 240;
  localparam int DEF_ADDR_W = 17;

  localparam int COORD_W = 9;
  localparam int COUNT_W = 17;

  localparam int R_HI = 11;
  localparam int R_LO = 8;
  localparam int G_HI = 7;
  localparam int G_LO = 4;
  localparam int B_HI = 3;
  localparam int B_LO = 0;

  localparam logic [3:0] DEF_R_MIN   = 4'hA;
  localparam logic [3:0] DEF_G_MAX   = 4'h5;
  localparam logic [3:0] DEF_B_MAX   = 4'h5;
  localparam int         DEF_MIN_PIX = 16;

  function automatic logic pixel_match(input logic [11:0] px, input logic [3:0] r_min,
                                       input logic [3:0] g_max, input logic [3:0] b_max);
    return (px[R_HI:R_LO] >= r_min) && (px[G_HI:G_LO] <= g_max) && (px[B_HI:B_LO] <= b_max);
  endfunction

endpackage

// File: rtl/color_bbox_scanner_frame_scan_counter.sv
// Raster-order x/y/address generator for the frame-buffer read port, plus the
// coordinates and issue-valid delayed one cycle to line up with the read data.
module frame_scan_counter
  import color_bbox_scanner_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  output logic [ADDR_W-1:0]  address,
  output logic [COORD_W-1:0] x_d,
  output logic [COORD_W-1:0] y_d,
  output logic               valid_d,
  output logic               last_issue
);

  logic [ADDR_W-1:0]  addr_reg;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic [COORD_W-1:0] x_d_reg;
  logic [COORD_W-1:0] y_d_reg;
  logic               valid_d_reg;

  assign last_issue = (x_reg == COORD_W'(H_RES - 1)) && (y_reg == COORD_W'(V_RES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      x_d_reg     <= '0;
      y_d_reg     <= '0;
      valid_d_reg <= 1'b0;
    end else if (clear) begin
      addr_reg    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      x_d_reg     <= '0;
      y_d_reg     <= '0;
      valid_d_reg <= 1'b0;
    end else begin
      valid_d_reg <= enable;
      if (enable) begin
        x_d_reg <= x_reg;
        y_d_reg <= y_reg;
        // The final address is held so the read port stays on the last pixel.
        if (!last_issue) begin
          addr_reg <= addr_reg + ADDR_W'(1);
          if (x_reg == COORD_W'(H_RES - 1)) begin
            x_reg <= '0;
            y_reg <= y_reg + COORD_W'(1);
          end else begin
            x_reg <= x_reg + COORD_W'(1);
          end
        end
      end
    end
  end

  assign address = addr_reg;
  assign x_d     = x_d_reg;
  assign y_d     = y_d_reg;
  assign valid_d = valid_d_reg;

endmodule

// File: rtl/color_bbox_scanner.sv
// Scans the captured frame once per start request, classifies each pixel against the
// target colour and publishes the bounding box and match count under start/done/ack.
module color_bbox_scanner
  import color_bbox_scanner_pkg::*;
#(
  parameter int         H_RES   = DEF_H_RES,
  parameter int         V_RES   = DEF_V_RES,
  parameter int         ADDR_W  = DEF_ADDR_W,
  parameter logic [3:0] R_MIN   = DEF_R_MIN,
  parameter logic [3:0] G_MAX   = DEF_G_MAX,
  parameter logic [3:0] B_MAX   = DEF_B_MAX,
  parameter int         MIN_PIX = DEF_MIN_PIX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_flag,
  input  logic               ack_flag,
  input  logic [11:0]        data_pixel,
  output logic [ADDR_W-1:0]  address_to_read,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [COUNT_W-1:0] pix_count,
  output logic               found,
  output logic               busy,
  output logic               done_flag,
  output logic               error_flag
);

  scan_state_t state_reg, state_next;

  logic               scan_clear;
  logic               scan_enable;
  logic [COORD_W-1:0] x_d;
  logic [COORD_W-1:0] y_d;
  logic               valid_d;
  logic               last_issue;

  frame_scan_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADDR_W(ADDR_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (scan_clear),
    .enable    (scan_enable),
    .address   (address_to_read),
    .x_d       (x_d),
    .y_d       (y_d),
    .valid_d   (valid_d),
    .last_issue(last_issue)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start_flag && !ack_flag) state_next = ST_SCAN;
      ST_SCAN:     if (!start_flag) state_next = ST_ERR;
                   else if (last_issue) state_next = ST_FLUSH;
      ST_FLUSH:    state_next = start_flag ? ST_DONE : ST_ERR;
      ST_DONE:     if (ack_flag) state_next = ST_ACK_WAIT;
      ST_ERR:      if (ack_flag) state_next = ST_ACK_WAIT;
      ST_ACK_WAIT: if (!ack_flag && !start_flag) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_clear  = (state_reg == ST_IDLE);
    scan_enable = (state_reg == ST_SCAN);
    busy        = (state_reg == ST_SCAN) || (state_reg == ST_FLUSH);
    done_flag   = (state_reg == ST_DONE);
    error_flag  = (state_reg == ST_ERR);
  end

  logic [COORD_W-1:0] wmin_x_reg, wmin_x_next;
  logic [COORD_W-1:0] wmax_x_reg, wmax_x_next;
  logic [COORD_W-1:0] wmin_y_reg, wmin_y_next;
  logic [COORD_W-1:0] wmax_y_reg, wmax_y_next;
  logic [COUNT_W-1:0] wcount_reg, wcount_next;
  logic               pix_hit;
  logic               acc_clear;
  logic               result_load;

  assign pix_hit     = valid_d && pixel_match(data_pixel, R_MIN, G_MAX, B_MAX);
  assign acc_clear   = (state_reg == ST_IDLE) && (state_next == ST_SCAN);
  assign result_load = (state_reg == ST_FLUSH) && (state_next == ST_DONE);

  always_comb begin
    wmin_x_next = wmin_x_reg;
    wmax_x_next = wmax_x_reg;
    wmin_y_next = wmin_y_reg;
    wmax_y_next = wmax_y_reg;
    wcount_next = wcount_reg;
    if (acc_clear) begin
      wmin_x_next = COORD_W'(H_RES - 1);
      wmax_x_next = '0;
      wmin_y_next = COORD_W'(V_RES - 1);
      wmax_y_next = '0;
      wcount_next = '0;
    end else if (pix_hit) begin
      if (x_d < wmin_x_reg) wmin_x_next = x_d;
      if (x_d > wmax_x_reg) wmax_x_next = x_d;
      if (y_d < wmin_y_reg) wmin_y_next = y_d;
      if (y_d > wmax_y_reg) wmax_y_next = y_d;
      if (wcount_reg != '1) wcount_next = wcount_reg + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wmin_x_reg <= '0;
      wmax_x_reg <= '0;
      wmin_y_reg <= '0;
      wmax_y_reg <= '0;
      wcount_reg <= '0;
    end else begin
      wmin_x_reg <= wmin_x_next;
      wmax_x_reg <= wmax_x_next;
      wmin_y_reg <= wmin_y_next;
      wmax_y_reg <= wmax_y_next;
      wcount_reg <= wcount_next;
    end
  end

  // Results load from the _next values so the pixel returned during FLUSH is included.
  logic               found_next;
  logic [COORD_W-1:0] x_min_reg, x_max_reg, y_min_reg, y_max_reg;
  logic [COUNT_W-1:0] pix_count_reg;
  logic               found_reg;

  assign found_next = (wcount_next >= COUNT_W'(MIN_PIX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_min_reg     <= '0;
      x_max_reg     <= '0;
      y_min_reg     <= '0;
      y_max_reg     <= '0;
      pix_count_reg <= '0;
      found_reg     <= 1'b0;
    end else if (result_load) begin
      x_min_reg     <= found_next ? wmin_x_next : '0;
      x_max_reg     <= found_next ? wmax_x_next : '0;
      y_min_reg     <= found_next ? wmin_y_next : '0;
      y_max_reg     <= found_next ? wmax_y_next : '0;
      pix_count_reg <= wcount_next;
      found_reg     <= found_next;
    end
  end

  assign x_min     = x_min_reg;
  assign x_max     = x_max_reg;
  assign y_min     = y_min_reg;
  assign y_max     = y_max_reg;
  assign pix_count = pix_count_reg;
  assign found     = found_reg;

endmodule

// File: tb/tb_color_bbox_scanner.sv
// Scoreboard bench for color_bbox_scanner on a reduced frame with a 1-cycle-latency
// frame memory model; expected results are pushed at start and checked when a flag rises.
module tb_color_bbox_scanner;

  localparam int TB_H = 32;
  localparam int TB_V = 24;
  localparam int TB_N = TB_H * TB_V;
  localparam int TIMEOUT = 3000;

  typedef struct {
    bit          is_err;
    logic [8:0]  xmn;
    logic [8:0]  xmx;
    logic [8:0]  ymn;
    logic [8:0]  ymx;
    logic [16:0] cnt;
    logic        fnd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_flag;
  logic        ack_flag;
  logic [11:0] data_pixel = 12'h000;
  logic [16:0] address_to_read;
  logic [8:0]  x_min, x_max, y_min, y_max;
  logic [16:0] pix_count;
  logic        found, busy, done_flag, error_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  logic [11:0] mem [0:TB_N-1];
  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  color_bbox_scanner #(
    .H_RES(TB_H),
    .V_RES(TB_V)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_flag     (start_flag),
    .ack_flag       (ack_flag),
    .data_pixel     (data_pixel),
    .address_to_read(address_to_read),
    .x_min          (x_min),
    .x_max          (x_max),
    .y_min          (y_min),
    .y_max          (y_max),
    .pix_count      (pix_count),
    .found          (found),
    .busy           (busy),
    .done_flag      (done_flag),
    .error_flag     (error_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    data_pixel <= (int'(address_to_read) < TB_N) ? mem[address_to_read] : 12'h000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag, input exp_t e);
    check({tag, ".x_min"}, 32'(x_min), 32'(e.xmn));
    check({tag, ".x_max"}, 32'(x_max), 32'(e.xmx));
    check({tag, ".y_min"}, 32'(y_min), 32'(e.ymn));
    check({tag, ".y_max"}, 32'(y_max), 32'(e.ymx));
    check({tag, ".pix_count"}, 32'(pix_count), 32'(e.cnt));
    check({tag, ".found"}, 32'(found), 32'(e.fnd));
  endtask

  // Monitor: one scoreboard entry per rising done_flag / error_flag.
  always @(negedge clk) begin
    if (reset === 1'b1 && ((done_flag && !done_prev) || (error_flag && !err_prev))) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_flag", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        $display("scan result: done=%0b err=%0b box x%0d..%0d y%0d..%0d count=%0d found=%0b",
                 done_flag, error_flag, x_min, x_max, y_min, y_max, pix_count, found);
        check("mon.done_flag", 32'(done_flag), 32'(!mon_e.is_err));
        check("mon.error_flag", 32'(error_flag), 32'(mon_e.is_err));
        check("mon.busy", 32'(busy), 32'd0);
        check_results("mon", mon_e);
        if (mon_e.lat > 0) check("mon.latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
        if (!mon_e.is_err) check("mon.last_address", 32'(address_to_read), 32'(TB_N - 1));
      end
    end
    done_prev <= done_flag;
    err_prev  <= error_flag;
  end

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < TB_N; i++) mem[i] = v;
  endtask

  task automatic put(input int x, input int y, input logic [11:0] v);
    mem[y * TB_H + x] = v;
  endtask

  task automatic run_scan(input exp_t e, input int abort_at, input int hold_at, input exp_t hold_e);
    int n;
    sb_q.push_back(e);
    @(negedge clk);
    start_flag = 1'b1;
    start_cyc  = cyc;
    n = 0;
    while (!(done_flag || error_flag) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
      if (abort_at > 0 && n == abort_at) start_flag = 1'b0;
      if (hold_at > 0 && n == hold_at) begin
        check("hold.busy", 32'(busy), 32'd1);
        check_results("hold", hold_e);
      end
    end
    if (n >= TIMEOUT) check("scan_timeout", 32'(n), 32'(TB_N + 2));
    start_flag = 1'b0;
    @(negedge clk);
    ack_flag = 1'b1;
    @(negedge clk);
    check("ack.flags_clear", 32'({done_flag, error_flag}), 32'd0);
    ack_flag = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle.address", 32'(address_to_read), 32'd0);
    check("idle.busy", 32'(busy), 32'd0);
  endtask

  exp_t e_zero, e_block, e_corner, e_abort, e_fifteen, e_none;

  initial begin
    e_none    = '{1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 17'd0, 1'b0, 0};
    e_zero    = '{1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 17'd0, 1'b0, TB_N + 2};
    e_block   = '{1'b0, 9'd10, 9'd14, 9'd5, 9'd8, 17'd20, 1'b1, TB_N + 2};
    e_corner  = '{1'b0, 9'd0, 9'd31, 9'd0, 9'd23, 17'd16, 1'b1, TB_N + 2};
    e_abort   = e_corner;
    e_abort.is_err = 1'b1;
    e_abort.lat    = 0;
    e_fifteen = '{1'b0, 9'd0, 9'd0, 9'd0, 9'd0, 17'd15, 1'b0, TB_N + 2};

    reset = 1'b0;
    start_flag = 1'b0;
    ack_flag = 1'b0;
    fill(12'h000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset.address", 32'(address_to_read), 32'd0);
    check("reset.flags", 32'({busy, done_flag, error_flag}), 32'd0);
    check_results("reset", e_none);

    // Blank frame
    run_scan(e_zero, 0, 0, e_none);

    // Red block x=10..14, y=5..8
    for (int y = 5; y <= 8; y++)
      for (int x = 10; x <= 14; x++) put(x, y, 12'hF00);
    run_scan(e_block, 0, 0, e_none);

    // Corners plus 14 boundary-threshold matches; near-miss colours must not count
    fill(12'h000);
    put(0, 0, 12'hF00);
    put(TB_H - 1, TB_V - 1, 12'hF00);
    for (int x = 3; x <= 16; x++) put(x, 12, 12'hA55);
    put(20, 20, 12'h955);
    put(21, 20, 12'hA65);
    put(22, 20, 12'hA56);
    run_scan(e_corner, 0, 300, e_block);

    // Abort mid-scan keeps previous results
    run_scan(e_abort, 100, 50, e_corner);

    // One below the detection minimum
    fill(12'h000);
    for (int x = 5; x <= 19; x++) put(x, 3, 12'hF00);
    run_scan(e_fifteen, 0, 300, e_corner);

    // start and ack together in IDLE is not accepted
    @(negedge clk);
    start_flag = 1'b1;
    ack_flag = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_start_ack.busy", 32'(busy), 32'd0);
    start_flag = 1'b0;
    ack_flag = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-scan clears every output at once
    fill(12'h000);
    for (int y = 5; y <= 8; y++)
      for (int x = 10; x <= 14; x++) put(x, y, 12'hF00);
    run_scan(e_block, 0, 0, e_none);
    start_flag = 1'b1;
    repeat (200) @(negedge clk);
    check("pre_reset.busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset.address", 32'(address_to_read), 32'd0);
    check("midreset.flags", 32'({busy, done_flag, error_flag}), 32'd0);
    check_results("midreset", e_none);
    start_flag = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Full scan after reset recovers
    run_scan(e_block, 0, 300, e_none);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
